// File: rtl/dds_sweep_gen.sv
// dds_sweep_gen: linear chirp generator driving the DDS accumulator tuning word (single, sawtooth, triangle).
// Latency: step/busy update on the CE edge sampling start; each word is then held for dwell+1 CE cycles.
// Backpressure: none; CE low freezes all state except the done clear. Triangle mode needs DDS_SWEEP_TRIANGLE_EN.
module dds_sweep_gen #(
    parameter int w_step  = 8,
    parameter int w_dwell = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CE,
    input  logic               start,
    input  logic               abort,
    input  logic [w_step-1:0]  f_start,
    input  logic [w_step-1:0]  f_stop,
    input  logic [w_step-1:0]  f_inc,
    input  logic [w_dwell-1:0] dwell,
    input  logic [1:0]         mode,
    output logic [w_step-1:0]  step,
    output logic               busy,
    output logic               done
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [w_dwell-1:0] DWELL_ONE = {{(w_dwell-1){1'b0}}, 1'b1};

    logic [0:0]         state;
    logic [w_step-1:0]  cfg_start;
    logic [w_step-1:0]  cfg_stop;
    logic [w_step-1:0]  cfg_inc;
    logic [w_dwell-1:0] cfg_dwell;
    logic [1:0]         cfg_mode;
    logic [w_dwell-1:0] dwell_cnt;
    logic               dir_up;
    logic               tgt_is_stop;
    logic [w_step-1:0]  target;
    logic [w_step-1:0]  nxt_fwd;

    // One extra bit catches carry/borrow so the word saturates at the target instead of wrapping.
    function automatic logic [w_step-1:0] clamp_step(input logic [w_step-1:0] cur,
                                                     input logic [w_step-1:0] inc,
                                                     input logic [w_step-1:0] tgt,
                                                     input logic              up);
        logic [w_step:0]   s;
        logic [w_step-1:0] r;
        if (up) begin
            s = {1'b0, cur} + {1'b0, inc};
            r = (s[w_step] || (s[w_step-1:0] > tgt)) ? tgt : s[w_step-1:0];
        end else begin
            s = {1'b0, cur} - {1'b0, inc};
            r = (s[w_step] || (s[w_step-1:0] < tgt)) ? tgt : s[w_step-1:0];
        end
        return r;
    endfunction

    assign target  = tgt_is_stop ? cfg_stop : cfg_start;
    assign nxt_fwd = clamp_step(step, cfg_inc, target, dir_up);
    assign busy    = (state == ST_RUN);

`ifdef DDS_SWEEP_TRIANGLE_EN
    logic [w_step-1:0] nxt_rev;
    assign nxt_rev = clamp_step(step, cfg_inc, tgt_is_stop ? cfg_start : cfg_stop, ~dir_up);
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            step        <= '0;
            done        <= 1'b0;
            dwell_cnt   <= '0;
            dir_up      <= 1'b1;
            tgt_is_stop <= 1'b1;
            cfg_start   <= '0;
            cfg_stop    <= '0;
            cfg_inc     <= '0;
            cfg_dwell   <= '0;
            cfg_mode    <= '0;
        end else begin
            done <= 1'b0;
            if (CE) begin
                if (start) begin
                    cfg_start   <= f_start;
                    cfg_stop    <= f_stop;
                    cfg_inc     <= f_inc;
                    cfg_dwell   <= dwell;
                    cfg_mode    <= mode;
                    step        <= f_start;
                    dwell_cnt   <= dwell;
                    dir_up      <= (f_stop >= f_start);
                    tgt_is_stop <= 1'b1;
                    state       <= ST_RUN;
                end else if (abort) begin
                    state <= ST_IDLE;
                end else if (state == ST_RUN) begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DWELL_ONE;
                    end else begin
                        dwell_cnt <= cfg_dwell;
                        if (step != target) begin
                            step <= nxt_fwd;
                        end else begin
                            case (cfg_mode)
`ifdef DDS_SWEEP_TRIANGLE_EN
                                2'd1: step <= cfg_start;
                                // Turn around at the endpoint: the first word of the new leg is emitted immediately.
                                2'd2: begin
                                    dir_up      <= ~dir_up;
                                    tgt_is_stop <= ~tgt_is_stop;
                                    step        <= nxt_rev;
                                end
`else
                                2'd1, 2'd2: step <= cfg_start;
`endif
                                default: begin
                                    state <= ST_IDLE;
                                    done  <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/dds_sweep_gen.md
# dds_sweep_gen

Frequency-sweep generator for the DDS core. It sits directly upstream of the phase accumulator and drives that accumulator's `step` (frequency tuning word) input. It produces linear chirps from a start word to a stop word, with a programmable dwell per frequency, in single, repeating-sawtooth or triangle mode. It has a start/abort control interface and a one-cycle completion pulse.

## Interface
Parameters:
- `w_step`, 8: width of the tuning word. Must equal the downstream accumulator's `w_step`.
- `w_dwell`, 16: width of the dwell counter.

Ports:
- `CLK`, in, 1: single clock; all logic on the rising edge.
- `RESET`, in, 1: synchronous, active-high reset.
- `CE`, in, 1: clock enable. The FSM, dwell counter and `step` advance only when CE=1.
- `start`, in, 1: sampled on CE cycles. Latches the configuration and begins a sweep.
- `abort`, in, 1: sampled on CE cycles. Stops the sweep and returns to IDLE.
- `f_start`, in, `w_step`: first tuning word.
- `f_stop`, in, `w_step`: last tuning word.
- `f_inc`, in, `w_step`: increment magnitude per frequency step.
- `dwell`, in, `w_dwell`: each word is held for dwell+1 CE cycles.
- `mode`, in, 2: 0 = single, 1 = sawtooth repeat, 2 = triangle, 3 = same as 0.
- `step`, out, `w_step`: registered tuning word to the accumulator.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: one-CLK pulse when a single sweep completes.

## Operation
- **States:** IDLE and RUN.
- **Configuration latch:** the configuration inputs are captured into shadow registers on an accepted `start`. Input changes during RUN have no effect.
- **Direction:** `dir_up` is set to (f_stop >= f_start) at start.
- **Step arithmetic:** computed in `w_step`+1 bits, with no wrap-around.
  - Up: next = step + f_inc. If next > f_stop or there is a carry out, next = f_stop.
  - Down: next = step − f_inc. If next < f_stop or there is a borrow, next = f_stop.
  - The clamp guarantees f_stop is emitted exactly.
- **Dwell counter:** loads `dwell` on every new word and decrements on each CE cycle. When it reaches 0 with CE=1, the block advances.
- **Advancing while step ≠ target:** `step` <= next.
- **Advancing while step == target** (target is f_stop, or f_start on a triangle return leg):
  - Mode 0/3: go to IDLE, `busy` <= 0, `done` <= 1. `step` holds its last value.
  - Mode 1: `step` <= f_start and the sweep continues.
  - Mode 2: reverse direction and swap the target between f_stop and f_start, then continue.
- **Zero increment:** f_inc = 0 holds `step` at f_start indefinitely. `done` never fires; the sweep ends only via `abort` or a new `start`.
- **Equal endpoints:** f_start == f_stop holds one word for dwell+1 cycles, then handles the endpoint per mode. In mode 2 this produces a constant output.
- **Start and abort:**
  - `start` in RUN restarts from the newly latched configuration.
  - `start` and `abort` together: `start` wins.
  - `abort` goes to IDLE, holds `step`, and produces no `done` pulse.
- **Output after a sweep:** `step` keeps its last value in IDLE, so the accumulator keeps producing that tone.

## Timing
- **Reset values:** `step`=0, `busy`=0, `done`=0, state IDLE, dwell counter=0, `dir_up`=1.
- **Reset priority:** RESET is synchronous and takes effect on any CLK edge regardless of CE. It overrides `start` and `abort`, and aborts a sweep mid-operation.
- **Start latency:** on the CE edge that samples `start`, `step` <= f_start and `busy` <= 1. The new values are visible one cycle after the edge.
- **Word spacing:** successive `step` changes are exactly dwell+1 CE cycles apart.
- **`done`:** set on the same edge that clears `busy`, and cleared on the next CLK edge whether or not CE is high.
- **CE low:** all state, including the dwell count, is frozen, except the `done` clear.
- **`step` register:** updates only on edges with CE=1. Combined with the accumulator, the phase slope changes one CLK cycle after `step` changes.

## Configuration
- **`DDS_SWEEP_TRIANGLE_EN` defined:** mode 2 behaves as triangle, as described above.
- **Not defined:** the direction-reversal logic is omitted and mode 2 behaves exactly like mode 1 (sawtooth). `dir_up` is still computed at start.

## Test plan
- **Single up-sweep:** f_start=10, f_stop=40, f_inc=10, dwell=2, mode 0, CE=1 → `step` = 10, 20, 30, 40, each held for 3 cycles. Then `busy` falls and `done`=1 for one cycle, and `step` stays 40.
- **Clamp, downward:** f_start=200, f_stop=5, f_inc=60, dwell=0, mode 0 → `step` = 200, 140, 80, 20, 5, then `done`.
- **Up-sweep saturation:** f_start=250, f_stop=255, f_inc=10 (w_step=8) → 250, 255 with no wrap to 4.
- **Triangle:** f_start=0, f_stop=3, f_inc=1, dwell=0, mode 2 → 0, 1, 2, 3, 2, 1, 0, 1, … With the macro undefined → 0, 1, 2, 3, 0, 1, …
- **Abort and restart:** `abort` mid-sweep at `step`=20 → `busy`=0, `step` stays 20, no `done`. Then `start` together with `abort` → restarts at f_start.
- **Reset and CE:** CE toggling 1/0 stretches each dwell to 2× cycles. RESET during RUN with CE=0 → next edge gives `step`=0, `busy`=0, `done`=0.
